// File: rtl/motor_pwm_driver.sv
// H-bridge PWM driver: period counter, boundary-latched signed command, reversal dead period.
// Optional short-brake on zero command is enabled by defining MOTOR_PWM_BRAKE_EN.
module motor_pwm_driver #(
    parameter int unsigned PWM_PERIOD = 5000,
    parameter int unsigned DUTY_MAX   = 4800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] motor_cmd,
    input  logic        cmd_valid,
    input  logic        enable,
    output logic        pwm,
    output logic        ain1,
    output logic        ain2,
    output logic        period_start,
    output logic        sat
);

    typedef enum logic [1:0] {StIdle, StRun, StDead} state_e;
    typedef enum logic [1:0] {DirNone, DirFwd, DirRev} dir_e;

    localparam logic [15:0] LastCnt = 16'(PWM_PERIOD - 1);
    localparam logic [16:0] DutyMax = 17'(DUTY_MAX);

    if (PWM_PERIOD < 2 || PWM_PERIOD > 65535) begin : g_bad_period
        $error("motor_pwm_driver: PWM_PERIOD outside 2..65535");
    end
    if (DUTY_MAX > PWM_PERIOD) begin : g_bad_duty
        $error("motor_pwm_driver: DUTY_MAX exceeds PWM_PERIOD");
    end

    state_e      st_q;
    dir_e        dir_q;
    logic [15:0] cnt_q;
    logic [15:0] pend_q;
    logic [16:0] duty_q;
    logic        brake_q;
    logic        pwm_q;
    logic        ain1_q;
    logic        ain2_q;
    logic        period_start_q;
    logic        sat_q;

    logic [15:0] cmd_eff;
    logic [16:0] cmd_ext;
    logic [16:0] mag;
    logic [16:0] duty_c;
    logic        sat_c;
    logic        brake_c;
    dir_e        sign_c;
    logic        boundary;
    logic        reverse;
    logic [15:0] cnt_nxt;

    always_comb begin
        // A write on the boundary edge itself is the last write before that boundary.
        cmd_eff  = cmd_valid ? motor_cmd : pend_q;
        cmd_ext  = {cmd_eff[15], cmd_eff};
        mag      = cmd_eff[15] ? (~cmd_ext + 17'd1) : cmd_ext;
        sat_c    = (mag > DutyMax);
        duty_c   = sat_c ? DutyMax : mag;
        if (cmd_eff == 16'd0) begin
            sign_c = DirNone;
        end else if (cmd_eff[15]) begin
            sign_c = DirRev;
        end else begin
            sign_c = DirFwd;
        end
`ifdef MOTOR_PWM_BRAKE_EN
        brake_c  = (sign_c == DirNone);
`else
        brake_c  = 1'b0;
`endif
        boundary = (st_q == StIdle) || (cnt_q == LastCnt);
        cnt_nxt  = boundary ? 16'd0 : cnt_q + 16'd1;
        reverse  = (sign_c != DirNone) && (dir_q != DirNone) && (sign_c != dir_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q           <= StIdle;
            dir_q          <= DirNone;
            cnt_q          <= 16'd0;
            pend_q         <= 16'd0;
            duty_q         <= 17'd0;
            brake_q        <= 1'b0;
            pwm_q          <= 1'b0;
            ain1_q         <= 1'b0;
            ain2_q         <= 1'b0;
            period_start_q <= 1'b0;
            sat_q          <= 1'b0;
        end else begin
            if (cmd_valid) begin
                pend_q <= motor_cmd;
            end
            if (!enable) begin
                st_q           <= StIdle;
                dir_q          <= DirNone;
                cnt_q          <= 16'd0;
                duty_q         <= 17'd0;
                brake_q        <= 1'b0;
                pwm_q          <= 1'b0;
                ain1_q         <= 1'b0;
                ain2_q         <= 1'b0;
                period_start_q <= 1'b0;
                sat_q          <= 1'b0;
            end else begin
                cnt_q          <= cnt_nxt;
                period_start_q <= boundary;
                if (boundary && reverse) begin
                    // Adopt the new direction now so the same command resumes RUN after DEAD.
                    st_q    <= StDead;
                    dir_q   <= sign_c;
                    duty_q  <= 17'd0;
                    brake_q <= 1'b0;
                    pwm_q   <= 1'b0;
                    ain1_q  <= 1'b0;
                    ain2_q  <= 1'b0;
                    sat_q   <= 1'b0;
                end else if (boundary) begin
                    st_q <= StRun;
                    if (sign_c != DirNone) begin
                        dir_q <= sign_c;
                    end
                    duty_q  <= duty_c;
                    brake_q <= brake_c;
                    sat_q   <= sat_c;
                    ain1_q  <= (sign_c == DirFwd) || brake_c;
                    ain2_q  <= (sign_c == DirRev) || brake_c;
                    pwm_q   <= brake_c || (duty_c != 17'd0);
                end else begin
                    pwm_q <= brake_q || ({1'b0, cnt_nxt} < duty_q);
                end
            end
        end
    end

    assign pwm          = pwm_q;
    assign ain1         = ain1_q;
    assign ain2         = ain2_q;
    assign period_start = period_start_q;
    assign sat          = sat_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Scoreboard bench for motor_pwm_driver: per-cycle expected outputs queued, compared at negedge.
module tb_motor_pwm_driver;

    localparam int Period  = 100;
    localparam int DutyMax = 90;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] motor_cmd = 16'd0;
    logic        cmd_valid = 1'b0;
    logic        enable = 1'b0;
    logic        pwm;
    logic        ain1;
    logic        ain2;
    logic        period_start;
    logic        sat;

    // {pwm, ain1, ain2, period_start, sat}
    logic [4:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    motor_pwm_driver #(
        .PWM_PERIOD(Period),
        .DUTY_MAX  (DutyMax)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .motor_cmd   (motor_cmd),
        .cmd_valid   (cmd_valid),
        .enable      (enable),
        .pwm         (pwm),
        .ain1        (ain1),
        .ain2        (ain2),
        .period_start(period_start),
        .sat         (sat)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic push_period(input int duty, input bit a1, input bit a2, input bit s,
                               input bit hi, input int n);
        for (int c = 0; c < n; c++) begin
            exp_q.push_back({hi || (c < duty), a1, a2, (c == 0), s});
        end
    endtask

    task automatic push_idle(input int n);
        for (int c = 0; c < n; c++) exp_q.push_back(5'b00000);
    endtask

    task automatic push_zero_cmd();
`ifdef MOTOR_PWM_BRAKE_EN
        push_period(0, 1'b1, 1'b1, 1'b0, 1'b1, Period);
`else
        push_period(0, 1'b0, 1'b0, 1'b0, 1'b0, Period);
`endif
    endtask

    task automatic write_cmd(input logic [15:0] v);
        motor_cmd = v;
        cmd_valid = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        repeat (3) begin
            @(negedge clk);
            got = {pwm, ain1, ain2, period_start, sat};
            n_checks++;
            if (got !== 5'b00000) begin
                n_fail++;
                $display("FAIL reset_hold: got %b want 00000", got);
            end
        end
        rst_n = 1'b1;
        push_idle(3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = {pwm, ain1, ain2, period_start, sat};
            n_checks++;
            if (got !== exp_q[0]) begin
                n_fail++;
                $display("FAIL idle_after_reset cyc %0d: got %b want %b", i, got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_basic();
        logic [4:0] got;
        logic [4:0] e;
        int total;
        enable = 1'b1;
        write_cmd(16'd40);
        push_period(40, 1'b1, 1'b0, 1'b0, 1'b0, Period);
        push_period(40, 1'b1, 1'b0, 1'b0, 1'b0, Period);
        total = exp_q.size();
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            got = {pwm, ain1, ain2, period_start, sat};
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL basic_fwd40 cyc %0d: got %b want %b", i, got, e);
            end
            if (i == 0) cmd_valid = 1'b0;
        end
    endtask

    task automatic test_saturation();
        logic [4:0] got;
        logic [4:0] e;
        int total;
        write_cmd(16'd200);
        push_period(90, 1'b1, 1'b0, 1'b1, 1'b0, Period);
        push_period(0, 1'b0, 1'b0, 1'b0, 1'b0, Period);
        push_period(90, 1'b0, 1'b1, 1'b1, 1'b0, Period);
        total = exp_q.size();
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            got = {pwm, ain1, ain2, period_start, sat};
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL saturation cyc %0d: got %b want %b", i, got, e);
            end
            if (i == 0 || i == 100) cmd_valid = 1'b0;
            if (i == 99) write_cmd(16'h8000);
        end
    endtask

    task automatic test_reverse();
        logic [4:0] got;
        logic [4:0] e;
        int total;
        write_cmd(16'd40);
        push_period(0, 1'b0, 1'b0, 1'b0, 1'b0, Period);
        push_period(40, 1'b1, 1'b0, 1'b0, 1'b0, Period);
        push_period(0, 1'b0, 1'b0, 1'b0, 1'b0, Period);
        push_period(30, 1'b0, 1'b1, 1'b0, 1'b0, Period);
        total = exp_q.size();
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            got = {pwm, ain1, ain2, period_start, sat};
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reverse_dead cyc %0d: got %b want %b", i, got, e);
            end
            if (i == 0 || i == 151 || i == 161) cmd_valid = 1'b0;
            if (i == 150) write_cmd(-16'sd70);
            if (i == 160) write_cmd(-16'sd30);
        end
    endtask

    task automatic test_zero_cmd();
        logic [4:0] got;
        logic [4:0] e;
        int total;
        write_cmd(16'd40);
        push_period(0, 1'b0, 1'b0, 1'b0, 1'b0, Period);
        push_period(40, 1'b1, 1'b0, 1'b0, 1'b0, Period);
        push_zero_cmd();
        push_period(40, 1'b1, 1'b0, 1'b0, 1'b0, Period);
        total = exp_q.size();
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            got = {pwm, ain1, ain2, period_start, sat};
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL zero_cmd cyc %0d: got %b want %b", i, got, e);
            end
            if (i == 0 || i == 151 || i == 251) cmd_valid = 1'b0;
            if (i == 150) write_cmd(16'd0);
            if (i == 250) write_cmd(16'd40);
        end
    endtask

    task automatic test_enable_drop();
        logic [4:0] got;
        logic [4:0] e;
        int total;
        push_period(40, 1'b1, 1'b0, 1'b0, 1'b0, 58);
        push_idle(5);
        push_period(50, 1'b0, 1'b1, 1'b0, 1'b0, Period);
        total = exp_q.size();
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            got = {pwm, ain1, ain2, period_start, sat};
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL enable_drop cyc %0d: got %b want %b", i, got, e);
            end
            if (i == 57) enable = 1'b0;
            if (i == 58) write_cmd(-16'sd50);
            if (i == 59) cmd_valid = 1'b0;
            if (i == 62) enable = 1'b1;
        end
    endtask

    task automatic test_reset_mid_period();
        logic [4:0] got;
        logic [4:0] e;
        int total;
        write_cmd(16'd40);
        push_period(0, 1'b0, 1'b0, 1'b0, 1'b0, Period);
        push_period(40, 1'b1, 1'b0, 1'b0, 1'b0, 21);
        total = exp_q.size();
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            got = {pwm, ain1, ain2, period_start, sat};
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL pre_reset cyc %0d: got %b want %b", i, got, e);
            end
            if (i == 0) cmd_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        got = {pwm, ain1, ain2, period_start, sat};
        n_checks++;
        if (got !== 5'b00000) begin
            n_fail++;
            $display("FAIL async_reset: got %b want 00000", got);
        end
        repeat (2) begin
            @(negedge clk);
            got = {pwm, ain1, ain2, period_start, sat};
            n_checks++;
            if (got !== 5'b00000) begin
                n_fail++;
                $display("FAIL reset_held: got %b want 00000", got);
            end
        end
        rst_n = 1'b1;
        push_zero_cmd();
        push_zero_cmd();
        push_period(40, 1'b1, 1'b0, 1'b0, 1'b0, Period);
        total = exp_q.size();
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            got = {pwm, ain1, ain2, period_start, sat};
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL post_reset cyc %0d: got %b want %b", i, got, e);
            end
            if (i == 150) write_cmd(16'd40);
            if (i == 151) cmd_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_reverse();
        test_zero_cmd();
        test_enable_drop();
        test_reset_mid_period();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/motor_pwm_driver.md
MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

Interface
REQ-001 SHALL have parameter PWM_PERIOD, default 5000: PWM period in clk cycles, legal range 2..65535.
REQ-002 SHALL have parameter DUTY_MAX, default 4800: saturation limit on duty magnitude; legal range 0..PWM_PERIOD.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port motor_cmd, input, 16 bits: signed two's-complement speed command from the PID control block.
REQ-006 SHALL have port cmd_valid, input, 1 bit: motor_cmd is captured when this bit is high.
REQ-007 SHALL have port enable, input, 1 bit: level; 0 forces the driver idle.
REQ-008 SHALL have port pwm, output, 1 bit: registered PWM drive to the H-bridge.
REQ-009 SHALL have ports ain1 and ain2, outputs, 1 bit each: registered H-bridge direction pins.
REQ-010 SHALL have port period_start, output, 1 bit: one-cycle pulse on the first cycle of each period.
REQ-011 SHALL have port sat, output, 1 bit: the applied command was clipped to DUTY_MAX.

Function
REQ-012 SHALL hold a pending register that loads motor_cmd on any cycle with cmd_valid=1; the last write before a boundary wins.
REQ-013 SHALL run a period counter 0..PWM_PERIOD-1 that wraps to 0; the cycle where the counter is 0 is the boundary, and period_start=1 on exactly that cycle.
REQ-014 SHALL apply the pending command only at a boundary; the duty and direction in force SHALL stay constant for the whole period.
REQ-015 SHALL compute magnitude as |cmd| in 17 bits, so -32768 gives 32768, then duty = min(magnitude, DUTY_MAX), with sat=1 when magnitude > DUTY_MAX.
REQ-016 SHALL drive pwm=1 for exactly duty consecutive cycles, starting on the period_start cycle; duty=0 SHALL give no high cycle and duty=PWM_PERIOD SHALL give a constant high.
REQ-017 SHALL decode direction as: cmd>0 -> ain1=1, ain2=0; cmd<0 -> ain1=0, ain2=1; cmd=0 -> coast (ain1=ain2=0, pwm=0), with the retained direction left unchanged.
REQ-018 SHALL implement an FSM with states IDLE, RUN and DEAD.
REQ-019 SHALL use these FSM transitions: IDLE->RUN on the first cycle enable=1, with the counter starting at 0 and that cycle treated as a boundary; RUN->DEAD at a boundary whose applied nonzero command has sign opposite to the retained direction; DEAD->RUN at the next boundary; any state->IDLE on the cycle after enable=0.
REQ-020 SHALL, in DEAD, hold pwm=0 and ain1=ain2=0 for one full period, then at the next boundary re-evaluate the latest pending command, which may re-enter DEAD.
REQ-021 SHALL, in IDLE, hold the counter at 0 and pwm, ain1, ain2, period_start and sat at 0, and clear the retained direction so the first nonzero command after IDLE enters RUN with no DEAD period.
REQ-022 SHALL keep the pending register loading in every state, including IDLE.

Reset
REQ-023 SHALL, while rst_n=0, force state=IDLE, counter=0, pending=0, retained direction cleared, and pwm=ain1=ain2=period_start=sat=0, immediately and without a clock edge.
REQ-024 SHALL resume after release of rst_n per REQ-019; a reset mid-period SHALL discard that period.

Configuration
REQ-025 SHALL recognise macro MOTOR_PWM_BRAKE_EN: when defined, cmd=0 in RUN SHALL give a short brake (ain1=ain2=1, pwm=1); when undefined, cmd=0 SHALL give the coast of REQ-017. DEAD and IDLE behaviour SHALL be the same in both builds.

Verification (bench uses PWM_PERIOD=100, DUTY_MAX=90)
REQ-026 SHALL cover: enable=1, cmd=+40 -> pwm high for 40 cycles from period_start, period 100 cycles, ain1=1, ain2=0, sat=0.
REQ-027 SHALL cover: cmd=+200, then cmd=-32768 -> duty 90 each period, sat=1, no wrap-around of the magnitude.
REQ-028 SHALL cover: running at +40, write -30 mid-period -> current period stays +40; next period is DEAD (pwm=0, ain1=ain2=0 for 100 cycles); the following period has ain2=1 and 30 high cycles.
REQ-029 SHALL cover: cmd=0 -> coast (all 0) without the macro, brake (ain1=ain2=pwm=1) with MOTOR_PWM_BRAKE_EN; then +40 after 0 while the retained direction is forward -> no DEAD period.
REQ-030 SHALL cover: enable dropped at counter 57 -> all outputs 0 on the next cycle; re-enable with pending -50 -> RUN immediately with ain2=1, no DEAD period.
REQ-031 SHALL cover: rst_n pulsed low at counter 20 with cmd +40 active -> outputs 0 asynchronously; after release, pending is 0, so the driver coasts until a new cmd_valid.
